pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max MEM_WAIT cycles before forced exit.
REQ-002 SHALL have parameter CNT_W, default 16, width of performance counters.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports IF_ID_RS1, IF_ID_RS2  in  5 each  source registers of the instruction in ID.
REQ-006 SHALL have ports ID_EX_RD, EX_MEM_RD, MEM_WB_RD  in  5 each  destination registers per stage.
REQ-007 SHALL have ports ID_EX_RegWrite, EX_MEM_RegWrite, MEM_WB_RegWrite, ID_EX_MemRead  in  1 each  stage control bits.
REQ-008 SHALL have port branch_taken  in  1  EX_MEM_Branch AND EX_MEM_zero.
REQ-009 SHALL have ports dmem_req  in  1  EX_MEM_MemRead OR EX_MEM_MemWrite; dmem_ready  in  1  data memory completion.
REQ-010 SHALL have outputs pc_en, IF_ID_en, EX_MEM_en  1 each  register enables.
REQ-011 SHALL have outputs IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  1 each  bubble insertion.
REQ-012 SHALL have outputs stall_cnt, flush_cnt  CNT_W each; mem_timeout  1  sticky error flag.

Function
REQ-013 SHALL implement FSM states RUN and MEM_WAIT.
REQ-014 SHALL transition RUN->MEM_WAIT when dmem_req=1 and dmem_ready=0; MEM_WAIT->RUN when dmem_ready=1 or wait count reaches MEM_TIMEOUT.
REQ-015 SHALL, while freeze is active (RUN with dmem_req&!dmem_ready, or MEM_WAIT with !dmem_ready and count<MEM_TIMEOUT), drive all enables 0, MEM_WB_flush 1, all other flushes 0.
REQ-016 SHALL, when no freeze and branch_taken=1, drive IF_ID_flush, ID_EX_flush, EX_MEM_flush 1, all enables 1 (3-instruction squash).
REQ-017 SHALL, when no freeze, no branch and a data hazard exists, drive pc_en 0, IF_ID_en 0, ID_EX_flush 1, EX_MEM_en 1, other flushes 0.
REQ-018 SHALL otherwise drive all enables 1 and all flushes 0.
REQ-019 SHALL apply priority freeze > branch > data hazard; outputs combinational from state and inputs, zero latency.
REQ-020 SHALL treat register 0 as never hazardous (RD=0 ignored).
REQ-021 SHALL hold a branch_taken that arrives during MEM_WAIT (EX/MEM frozen) and act on it in the cycle dmem_ready=1.
REQ-022 SHALL count MEM_WAIT cycles in a wait counter cleared on entry; on reaching MEM_TIMEOUT set mem_timeout (sticky until rst) and release the pipeline that cycle.
REQ-023 SHALL increment stall_cnt on each freeze or hazard-stall cycle and flush_cnt on each branch-squash cycle; both saturate at all-ones.

Reset
REQ-024 SHALL, on rst=1 at posedge, set state RUN, wait counter 0, stall_cnt 0, flush_cnt 0, mem_timeout 0.
REQ-025 SHALL, while rst=1, drive all enables 1 and all flushes 0 regardless of other inputs; rst mid-MEM_WAIT aborts the wait.

Configuration
REQ-026 SHALL use macro PIPE_FORWARDING_EN.
REQ-027 SHALL, with PIPE_FORWARDING_EN defined, flag a data hazard only for load-use: ID_EX_MemRead=1 and ID_EX_RD matches RS1 or RS2 (1-cycle stall).
REQ-028 SHALL, without it, flag a data hazard when any of ID_EX/EX_MEM/MEM_WB has RegWrite=1 and RD matching RS1 or RS2 (stall until producer retires, up to 3 cycles).

Structure
REQ-029 SHALL place state enum (RUN, MEM_WAIT) and constant REG_ZERO=5'd0 in shared package pipe_ctrl_pkg.
REQ-030 SHALL isolate hazard comparison in one combinational sub-module hazard_detect; FSM and counters remain in pipe_hazard_ctrl.

Verification
REQ-031 Load-use, forwarding on: ID_EX_MemRead=1, ID_EX_RD=5, IF_ID_RS1=5 -> pc_en=0, IF_ID_en=0, ID_EX_flush=1 for exactly 1 cycle; stall_cnt=1.
REQ-032 No forwarding: EX_MEM_RD=7, EX_MEM_RegWrite=1, IF_ID_RS2=7 -> stall asserted; RD=0 with RS2=0 -> no stall.
REQ-033 Branch: branch_taken=1, no mem request -> three flushes 1 for 1 cycle; flush_cnt=1.
REQ-034 Mem wait: dmem_req=1, dmem_ready low 3 cycles then high -> all enables 0 for 3 cycles, MEM_WAIT exited on 4th; branch_taken=1 concurrently -> squash in ready cycle.
REQ-035 Timeout: dmem_ready held 0 -> release after MEM_TIMEOUT=15 wait cycles, mem_timeout=1 until rst.
REQ-036 Reset mid-MEM_WAIT: rst=1 -> next cycle state RUN, counters 0, mem_timeout 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline hazard controller:
//   state_t  - controller FSM states (RUN, MEM_WAIT)
//   ctrl_t   - bundle of pipeline register enables and bubble-insert flushes
//   REG_ZERO - architectural zero register, never a real producer
//   rd_hit() - true when a non-zero destination feeds either ID source
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } ctrl_t;

  // Normal flow: everything advances, nothing squashed.
  localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  // Data memory busy: hold every stage, feed a bubble into WB.
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  // Taken branch resolved in MEM: kill the three younger instructions.
  localparam ctrl_t CTRL_SQUASH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  // Data hazard: hold PC and IF/ID, bubble into EX, let older stages drain.
  localparam ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  function automatic logic rd_hit(input logic [4:0] rd,
                                  input logic [4:0] rs1,
                                  input logic [4:0] rs2);
    return (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side - drives register ids and stage control bits,
//            receives enables and flushes
//   slave  : controller side - the reverse
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;

  logic [4:0] IF_ID_RS1;
  logic [4:0] IF_ID_RS2;
  logic [4:0] ID_EX_RD;
  logic [4:0] EX_MEM_RD;
  logic [4:0] MEM_WB_RD;
  logic       ID_EX_RegWrite;
  logic       EX_MEM_RegWrite;
  logic       MEM_WB_RegWrite;
  logic       ID_EX_MemRead;

  logic       pc_en;
  logic       IF_ID_en;
  logic       EX_MEM_en;
  logic       IF_ID_flush;
  logic       ID_EX_flush;
  logic       EX_MEM_flush;
  logic       MEM_WB_flush;

  modport master (
    output IF_ID_RS1, IF_ID_RS2, ID_EX_RD, EX_MEM_RD, MEM_WB_RD,
    output ID_EX_RegWrite, EX_MEM_RegWrite, MEM_WB_RegWrite, ID_EX_MemRead,
    input  pc_en, IF_ID_en, EX_MEM_en,
    input  IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush
  );

  modport slave (
    input  IF_ID_RS1, IF_ID_RS2, ID_EX_RD, EX_MEM_RD, MEM_WB_RD,
    input  ID_EX_RegWrite, EX_MEM_RegWrite, MEM_WB_RegWrite, ID_EX_MemRead,
    output pc_en, IF_ID_en, EX_MEM_en,
    output IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational RAW hazard check for the instruction in ID.
// Build option PIPE_FORWARDING_EN:
//   defined   - full forwarding exists, only a load in EX can hurt (load-use)
//   undefined - no forwarding, any in-flight writer of a source register stalls
// Ports:
//   rs1, rs2                      in  ID source registers
//   id_ex_rd, ex_mem_rd, mem_wb_rd in destination registers per stage
//   id_ex_wr, ex_mem_wr, mem_wb_wr in RegWrite per stage
//   id_ex_mem_read                 in  load in EX
//   hazard                         out stall request
// -----------------------------------------------------------------------------
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] id_ex_rd,
  input  logic [4:0] ex_mem_rd,
  input  logic [4:0] mem_wb_rd,
  input  logic       id_ex_wr,
  input  logic       ex_mem_wr,
  input  logic       mem_wb_wr,
  input  logic       id_ex_mem_read,
  output logic       hazard
);

`ifdef PIPE_FORWARDING_EN
  logic unused_no_fwd;
  assign unused_no_fwd = ^{ex_mem_rd, mem_wb_rd, id_ex_wr, ex_mem_wr, mem_wb_wr};
  assign hazard = id_ex_mem_read && rd_hit(id_ex_rd, rs1, rs2);
`else
  logic unused_fwd;
  assign unused_fwd = id_ex_mem_read;
  assign hazard = (id_ex_wr  && rd_hit(id_ex_rd,  rs1, rs2)) ||
                  (ex_mem_wr && rd_hit(ex_mem_rd, rs1, rs2)) ||
                  (mem_wb_wr && rd_hit(mem_wb_rd, rs1, rs2));
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall/flush controller for a 5-stage pipeline. Priority: memory freeze >
// taken-branch squash > data-hazard stall. Controls are combinational from
// state and inputs; counters and the timeout flag are registered.
// Build option PIPE_FORWARDING_EN selects load-use-only hazard detection.
// Parameters:
//   MEM_TIMEOUT - MEM_WAIT cycles tolerated before the pipeline is released
//   CNT_W       - width of the saturating performance counters
// Ports:
//   clk, rst     in  clock, synchronous active-high reset
//   pipe         slave modport: register ids/controls in, enables/flushes out
//   branch_taken in  taken branch resolved in EX/MEM
//   dmem_req     in  EX/MEM holds a load or store
//   dmem_ready   in  data memory completes this cycle
//   stall_cnt    out freeze + hazard stall cycles
//   flush_cnt    out branch squash cycles
//   mem_timeout  out sticky: a memory access was abandoned on timeout
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave pipe,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  // One spare bit so the counter can hold MEM_TIMEOUT even when it is 0.
  localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              branch_pend;
  logic              hazard;
  logic              freeze, squash, hz_stall, timeout_hit;
  ctrl_t             ctrl;

  hazard_detect u_hazard_detect (
    .rs1            (pipe.IF_ID_RS1),
    .rs2            (pipe.IF_ID_RS2),
    .id_ex_rd       (pipe.ID_EX_RD),
    .ex_mem_rd      (pipe.EX_MEM_RD),
    .mem_wb_rd      (pipe.MEM_WB_RD),
    .id_ex_wr       (pipe.ID_EX_RegWrite),
    .ex_mem_wr      (pipe.EX_MEM_RegWrite),
    .mem_wb_wr      (pipe.MEM_WB_RegWrite),
    .id_ex_mem_read (pipe.ID_EX_MemRead),
    .hazard         (hazard)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    freeze      = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = RUN;
        end else if (wait_cnt >= WAIT_MAX) begin
          timeout_hit = 1'b1;
          state_nxt   = RUN;
        end else begin
          freeze = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase

    // A branch seen while EX/MEM was frozen is remembered in branch_pend.
    squash   = !freeze && (branch_taken || branch_pend);
    hz_stall = !freeze && !squash && hazard;

    ctrl = CTRL_RUN;
    if (!rst) begin
      if (freeze)        ctrl = CTRL_FREEZE;
      else if (squash)   ctrl = CTRL_SQUASH;
      else if (hz_stall) ctrl = CTRL_STALL;
    end
  end

  assign pipe.pc_en        = ctrl.pc_en;
  assign pipe.IF_ID_en     = ctrl.if_id_en;
  assign pipe.EX_MEM_en    = ctrl.ex_mem_en;
  assign pipe.IF_ID_flush  = ctrl.if_id_flush;
  assign pipe.ID_EX_flush  = ctrl.id_ex_flush;
  assign pipe.EX_MEM_flush = ctrl.ex_mem_flush;
  assign pipe.MEM_WB_flush = ctrl.mem_wb_flush;

  // NOTE: reset is synchronous, so it only takes effect at a clock edge;
  // state updates use non-blocking assignment so all flops see old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      branch_pend <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      // Cleared on entry: counts only consecutive cycles spent in MEM_WAIT.
      wait_cnt    <= (state == MEM_WAIT && state_nxt == MEM_WAIT) ? wait_cnt + 1'b1 : '0;
      branch_pend <= freeze && (branch_taken || branch_pend);
      if ((freeze || hz_stall) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (squash && (flush_cnt != '1))                flush_cnt <= flush_cnt + 1'b1;
      if (timeout_hit)                                mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed scenarios with hand-computed expectations, then randomized traffic
// compared every cycle against a behavioural model of the controller rules.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 16;
  localparam int SAT         = (1 << CNT_W) - 1;

`ifdef PIPE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             branch_taken, dmem_req, dmem_ready;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_timeout;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe         (bus),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .mem_timeout  (mem_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_valid = 1'b0;
  bit m_in_wait, m_held_br, m_sticky;
  int m_waited, m_stall, m_flush;
  bit fz, br, sq, hz;
  logic [6:0] exp_o, act_o;

  function automatic bit model_hazard();
    logic [4:0] rd [3];
    bit         wr [3];
    bit         h;
    h = 1'b0;
    if (FWD) begin
      h = bus.ID_EX_MemRead && (bus.ID_EX_RD != 5'd0) &&
          (bus.ID_EX_RD == bus.IF_ID_RS1 || bus.ID_EX_RD == bus.IF_ID_RS2);
    end else begin
      rd[0] = bus.ID_EX_RD;  wr[0] = bus.ID_EX_RegWrite;
      rd[1] = bus.EX_MEM_RD; wr[1] = bus.EX_MEM_RegWrite;
      rd[2] = bus.MEM_WB_RD; wr[2] = bus.MEM_WB_RegWrite;
      for (int k = 0; k < 3; k++)
        if (wr[k] && rd[k] != 5'd0 && (rd[k] == bus.IF_ID_RS1 || rd[k] == bus.IF_ID_RS2))
          h = 1'b1;
    end
    return h;
  endfunction

  // Compare process: outputs are stable mid-cycle, model advances per cycle.
  always @(negedge clk) begin
    act_o = {bus.pc_en, bus.IF_ID_en, bus.EX_MEM_en, bus.IF_ID_flush,
             bus.ID_EX_flush, bus.EX_MEM_flush, bus.MEM_WB_flush};
    if (rst) begin
      check("ctrl_in_reset", 32'(act_o), 32'(7'b1110000));
    end else if (m_valid) begin
      fz = m_in_wait ? (!dmem_ready && m_waited < MEM_TIMEOUT) : (dmem_req && !dmem_ready);
      br = branch_taken || m_held_br;
      sq = !fz && br;
      hz = !fz && !br && model_hazard();
      if (fz)      exp_o = 7'b0000001;
      else if (sq) exp_o = 7'b1111110;
      else if (hz) exp_o = 7'b0010100;
      else         exp_o = 7'b1110000;
      check("ctrl", 32'(act_o), 32'(exp_o));
    end
    if (m_valid) begin
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
      check("mem_timeout", 32'(mem_timeout), 32'(m_sticky));
    end
    if (rst) begin
      m_valid = 1'b1; m_in_wait = 1'b0; m_held_br = 1'b0; m_sticky = 1'b0;
      m_waited = 0; m_stall = 0; m_flush = 0;
    end else if (m_valid) begin
      m_held_br = fz && br;
      if ((fz || hz) && m_stall < SAT) m_stall++;
      if (sq && m_flush < SAT) m_flush++;
      if (!m_in_wait) begin
        if (dmem_req && !dmem_ready) begin m_in_wait = 1'b1; m_waited = 0; end
      end else if (dmem_ready) begin
        m_in_wait = 1'b0;
      end else if (m_waited >= MEM_TIMEOUT) begin
        m_in_wait = 1'b0; m_sticky = 1'b1;
      end else begin
        m_waited++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.IF_ID_RS1 = 5'd0; bus.IF_ID_RS2 = 5'd0;
    bus.ID_EX_RD = 5'd0; bus.EX_MEM_RD = 5'd0; bus.MEM_WB_RD = 5'd0;
    bus.ID_EX_RegWrite = 1'b0; bus.EX_MEM_RegWrite = 1'b0;
    bus.MEM_WB_RegWrite = 1'b0; bus.ID_EX_MemRead = 1'b0;
    branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    cyc(); idle(); rst = 1'b1;
    cyc(); rst = 1'b0;
  endtask

  int  n_frozen;
  bit  released;

  initial begin
    idle();
    rst = 1'b1; dmem_req = 1'b1; branch_taken = 1'b1;  // reset must override these
    smp(); smp();
    check("rst_pc_en", 32'(bus.pc_en), 32'd1);
    check("rst_mem_wb_flush", 32'(bus.MEM_WB_flush), 32'd0);
    check("rst_if_id_flush", 32'(bus.IF_ID_flush), 32'd0);
    cyc(); idle(); rst = 1'b0;
    smp();
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    check("rst_timeout", 32'(mem_timeout), 32'd0);

    // Load-use / ID_EX writer of RS1: one stall cycle in either build.
    cyc(); bus.ID_EX_RD = 5'd5; bus.IF_ID_RS1 = 5'd5;
    bus.ID_EX_RegWrite = 1'b1; bus.ID_EX_MemRead = 1'b1;
    smp();
    check("lu_pc_en", 32'(bus.pc_en), 32'd0);
    check("lu_if_id_en", 32'(bus.IF_ID_en), 32'd0);
    check("lu_id_ex_flush", 32'(bus.ID_EX_flush), 32'd1);
    check("lu_ex_mem_en", 32'(bus.EX_MEM_en), 32'd1);
    cyc(); idle();
    smp();
    check("lu_released", 32'(bus.pc_en), 32'd1);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Register zero never hazards; EX_MEM producer only matters without forwarding.
    cyc(); bus.EX_MEM_RD = 5'd0; bus.EX_MEM_RegWrite = 1'b1; bus.IF_ID_RS2 = 5'd0;
    smp();
    check("r0_no_stall", 32'(bus.pc_en), 32'd1);
    cyc(); bus.EX_MEM_RD = 5'd7; bus.IF_ID_RS2 = 5'd7;
    smp();
    check("exmem_stall", 32'(bus.pc_en), FWD ? 32'd1 : 32'd0);

    // Branch squash.
    pulse_reset(); branch_taken = 1'b1;
    smp();
    check("br_flushes", 32'({bus.IF_ID_flush, bus.ID_EX_flush, bus.EX_MEM_flush}), 32'd7);
    check("br_mem_wb_flush", 32'(bus.MEM_WB_flush), 32'd0);
    check("br_pc_en", 32'(bus.pc_en), 32'd1);
    cyc(); branch_taken = 1'b0;
    smp();
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_one_cycle", 32'(bus.IF_ID_flush), 32'd0);

    // Memory wait of 3 cycles; branch seen only while frozen squashes on ready.
    pulse_reset(); dmem_req = 1'b1; dmem_ready = 1'b0;
    smp();
    check("mw_c1_en", 32'({bus.pc_en, bus.IF_ID_en, bus.EX_MEM_en}), 32'd0);
    check("mw_c1_wb", 32'(bus.MEM_WB_flush), 32'd1);
    cyc(); branch_taken = 1'b1;
    smp();
    check("mw_c2_en", 32'({bus.pc_en, bus.IF_ID_en, bus.EX_MEM_en}), 32'd0);
    cyc(); branch_taken = 1'b0;
    smp();
    check("mw_c3_en", 32'({bus.pc_en, bus.IF_ID_en, bus.EX_MEM_en}), 32'd0);
    cyc(); dmem_ready = 1'b1;
    smp();
    check("mw_c4_pc_en", 32'(bus.pc_en), 32'd1);
    check("mw_c4_squash", 32'(bus.EX_MEM_flush), 32'd1);
    check("mw_c4_wb", 32'(bus.MEM_WB_flush), 32'd0);
    cyc(); idle();
    smp();
    check("mw_back_in_run", 32'(bus.pc_en), 32'd1);
    check("mw_stall_cnt", 32'(stall_cnt), 32'd3);
    check("mw_flush_cnt", 32'(flush_cnt), 32'd1);

    // Timeout: entry cycle plus MEM_TIMEOUT wait cycles frozen, then release.
    pulse_reset(); dmem_req = 1'b1; dmem_ready = 1'b0;
    n_frozen = 0; released = 1'b0;
    for (int i = 0; i < 40 && !released; i++) begin
      smp();
      if (bus.pc_en) released = 1'b1;
      else begin n_frozen++; cyc(); end
    end
    check("to_released", 32'(released), 32'd1);
    check("to_frozen_cycles", 32'(n_frozen), 32'(MEM_TIMEOUT + 1));
    check("to_flag_lag", 32'(mem_timeout), 32'd0);
    cyc(); idle();
    smp();
    check("to_flag_set", 32'(mem_timeout), 32'd1);
    check("to_stall_cnt", 32'(stall_cnt), 32'(MEM_TIMEOUT + 1));
    cyc();
    smp();
    check("to_flag_sticky", 32'(mem_timeout), 32'd1);

    // Reset in the middle of a wait.
    cyc(); dmem_req = 1'b1; dmem_ready = 1'b0;
    smp();
    cyc();
    smp();
    cyc(); rst = 1'b1;
    smp();
    check("rw_pc_en", 32'(bus.pc_en), 32'd1);
    check("rw_wb_flush", 32'(bus.MEM_WB_flush), 32'd0);
    cyc(); rst = 1'b0; idle();
    smp();
    check("rw_run", 32'(bus.pc_en), 32'd1);
    check("rw_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rw_flush_cnt", 32'(flush_cnt), 32'd0);
    check("rw_timeout", 32'(mem_timeout), 32'd0);

    // Randomized traffic; the second half starves the memory to reach timeouts.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst                 = ($urandom_range(0, 199) == 0);
      bus.IF_ID_RS1       = 5'($urandom_range(0, 3));
      bus.IF_ID_RS2       = 5'($urandom_range(0, 3));
      bus.ID_EX_RD        = 5'($urandom_range(0, 3));
      bus.EX_MEM_RD       = 5'($urandom_range(0, 3));
      bus.MEM_WB_RD       = 5'($urandom_range(0, 3));
      bus.ID_EX_RegWrite  = 1'($urandom_range(0, 1));
      bus.EX_MEM_RegWrite = 1'($urandom_range(0, 1));
      bus.MEM_WB_RegWrite = 1'($urandom_range(0, 1));
      bus.ID_EX_MemRead   = 1'($urandom_range(0, 1));
      branch_taken        = ($urandom_range(0, 7) == 0);
      dmem_req            = ($urandom_range(0, 3) == 0);
      dmem_ready          = (i < 1500) ? 1'($urandom_range(0, 1))
                                       : ($urandom_range(0, 24) == 0);
    end
    cyc(); idle(); rst = 1'b0;
    smp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
